// File: rtl/alu_mdu.sv
// Integer execute unit: RV base ALU ops in one registered cycle, plus iterative
// M-extension multiply (shift-add) and restoring divide behind a valid/ready handshake.
module alu_mdu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      funct3,
  input  logic            is_sub_sra,
  input  logic            is_muldiv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned ShW     = $clog2(XLEN);
  localparam int unsigned CntW    = $clog2(XLEN);
  localparam int unsigned MulIter = XLEN / MUL_STEP;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [1:0]          f3_q, f3_d;
  logic [XLEN-1:0]     result_q, result_d;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

  // Single-cycle base ALU
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  assign shamt = op2[ShW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'b000: alu_res = is_sub_sra ? op1 - op2 : op1 + op2;
      3'b001: alu_res = op1 << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      3'b100: alu_res = op1 ^ op2;
      3'b101: alu_res = is_sub_sra ? $unsigned($signed(op1) >>> shamt) : op1 >> shamt;
      3'b110: alu_res = op1 | op2;
      3'b111: alu_res = op1 & op2;
    endcase
  end

  // Operand signs and magnitudes for the signed M-extension forms
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;

  always_comb begin
    if (funct3[2]) begin
      s1 = op1[XLEN-1] & ~funct3[0];
      s2 = op2[XLEN-1] & ~funct3[0];
    end else begin
      s1 = op1[XLEN-1] & ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
      s2 = op2[XLEN-1] & (funct3[1:0] == 2'b01);
    end
  end

  assign mag1     = s1 ? -op1 : op1;
  assign mag2     = s2 ? -op2 : op2;
  assign div_zero = (op2 == '0);
  assign div_ovf  = ~funct3[0] & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&op2);

  // Multiply step: prod_q = {acc, remaining multiplier bits}, MUL_STEP bits retired per cycle
  logic [MUL_STEP-1:0]      digit;
  logic [XLEN+MUL_STEP-1:0] partial, upper;
  logic [2*XLEN-1:0]        mul_next, mul_full;
  assign digit    = prod_q[MUL_STEP-1:0];
  assign partial  = {{MUL_STEP{1'b0}}, a_q} * {{XLEN{1'b0}}, digit};
  assign upper    = {{MUL_STEP{1'b0}}, prod_q[2*XLEN-1:XLEN]} + partial;
  assign mul_next = {upper, prod_q[XLEN-1:MUL_STEP]};
  assign mul_full = neg_q ? -mul_next : mul_next;

  // Restoring divide step: prod_q = {remainder, dividend shifting into quotient}
  logic [XLEN:0]     rem_shift, diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_fin, rem_fin;
  assign rem_shift = prod_q[2*XLEN-1:XLEN-1];
  assign diff      = rem_shift - {1'b0, b_q};
  assign div_next  = diff[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
  assign quo_fin   = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
  assign rem_fin   = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    f3_d     = f3_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          f3_d = funct3[1:0];
          if (!is_muldiv) begin
            result_d = alu_res;
            state_d  = StDone;
          end else if (!funct3[2]) begin
            a_d     = mag1;
            prod_d  = {{XLEN{1'b0}}, mag2};
            neg_d   = s1 ^ s2;
            cnt_d   = CntW'(MulIter - 1);
            state_d = StMul;
          end else if (div_zero) begin
            result_d = funct3[1] ? op1 : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : op1;
            state_d  = StDone;
          end else begin
            b_d     = mag2;
            prod_d  = {{XLEN{1'b0}}, mag1};
            neg_d   = s1 ^ s2;
            rneg_d  = s1;
            cnt_d   = CntW'(XLEN - 1);
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        prod_d = mul_next;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          result_d = (f3_q == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
          state_d  = StDone;
        end
      end
      StDiv: begin
        prod_d = div_next;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          result_d = f3_q[1] ? rem_fin : quo_fin;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      f3_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      f3_q     <= f3_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vectors with literal expectations, an
// arithmetic reference model, and a per-cycle monitor for handshake, latency and result.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [2:0]  funct3 = '0;
  logic        is_sub_sra = 1'b0;
  logic        is_muldiv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [31:0] result4;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32), .MUL_STEP(1)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .funct3(funct3), .is_sub_sra(is_sub_sra),
    .is_muldiv(is_muldiv), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  alu_mdu #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4),
    .op1(op1), .op2(op2), .funct3(funct3), .is_sub_sra(is_sub_sra),
    .is_muldiv(is_muldiv), .out_valid(out_valid4), .out_ready(out_ready4), .result(result4)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  f3;
    logic        sub;
    logic        md;
    logic [31:0] res;
    int          lat;
    bit          pinned;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  vec_t vecs[$];
  bit   busy = 1'b0;
  bit   seen = 1'b0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] model(input vec_t v);
    logic [63:0] ea, eb, p;
    int          sa, sb;
    logic [4:0]  sh;
    sh = v.op2[4:0];
    if (!v.md) begin
      case (v.f3)
        3'd0: return v.sub ? v.op1 - v.op2 : v.op1 + v.op2;
        3'd1: return v.op1 << sh;
        3'd2: return ($signed(v.op1) < $signed(v.op2)) ? 32'd1 : 32'd0;
        3'd3: return (v.op1 < v.op2) ? 32'd1 : 32'd0;
        3'd4: return v.op1 ^ v.op2;
        3'd5: return v.sub ? $unsigned($signed(v.op1) >>> sh) : v.op1 >> sh;
        3'd6: return v.op1 | v.op2;
        default: return v.op1 & v.op2;
      endcase
    end
    if (!v.f3[2]) begin
      ea = (v.f3 == 3'd1 || v.f3 == 3'd2) ? {{32{v.op1[31]}}, v.op1} : {32'd0, v.op1};
      eb = (v.f3 == 3'd1) ? {{32{v.op2[31]}}, v.op2} : {32'd0, v.op2};
      p  = ea * eb;
      return (v.f3 == 3'd0) ? p[31:0] : p[63:32];
    end
    if (v.op2 == 32'd0) return v.f3[1] ? v.op1 : 32'hFFFF_FFFF;
    if (!v.f3[0]) begin
      if (v.op1 == 32'h8000_0000 && v.op2 == 32'hFFFF_FFFF) return v.f3[1] ? 32'd0 : v.op1;
      sa = v.op1;
      sb = v.op2;
      return v.f3[1] ? sa % sb : sa / sb;
    end
    return v.f3[1] ? v.op1 % v.op2 : v.op1 / v.op2;
  endfunction

  function automatic int mlat(input vec_t v);
    if (!v.md) return 1;
    if (!v.f3[2]) return 33;
    if (v.op2 == 32'd0) return 1;
    if (!v.f3[0] && v.op1 == 32'h8000_0000 && v.op2 == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                     input logic sub, input logic md, input logic [31:0] res, input int lat);
    vec_t v;
    v.op1 = a; v.op2 = b; v.f3 = f3; v.sub = sub; v.md = md;
    v.res = res; v.lat = lat; v.pinned = 1'b1;
    vecs.push_back(v);
  endtask

  // Caller is at posedge+1 with the unit idle; request is accepted on the next edge
  task automatic launch(input vec_t v);
    exp_t e;
    if (v.pinned) begin
      chk("model_res", model(v), v.res);
      chk("model_lat", 32'(mlat(v)), 32'(v.lat));
    end
    e.res = v.res;
    e.lat = v.lat;
    exp_q.push_back(e);
    op1 = v.op1; op2 = v.op2; funct3 = v.f3; is_sub_sra = v.sub; is_muldiv = v.md;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom); is_sub_sra = 1'($urandom);
    is_muldiv = 1'($urandom);
  endtask

  task automatic wait_done(input int hold);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (out_valid || n >= 200) break;
    end
    chk("done_seen", 32'(out_valid), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int hold, input bit toggle);
    if (hold > 0) out_ready = 1'b0;
    launch(v);
    if (toggle) begin
      repeat (20) begin
        @(posedge clk); #1;
        in_valid = 1'($urandom);
        op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom);
      end
      in_valid = 1'b0;
    end
    wait_done(hold);
  endtask

  // Monitor: handshake, latency from accept, and result held while out_valid
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", result, 32'd0);
      exp_q.delete();
      busy = 1'b0;
      seen = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!busy));
      if (!busy) begin
        if (out_valid) chk("spurious_out_valid", 32'(out_valid), 32'd0);
        if (in_valid && in_ready) begin
          busy = 1'b1;
          seen = 1'b0;
          cyc  = 0;
        end
      end else begin
        cyc++;
        if (out_valid && exp_q.size() > 0) begin
          if (!seen) begin
            chk("latency", 32'(cyc), 32'(exp_q[0].lat));
            seen = 1'b1;
          end
          chk("result", result, exp_q[0].res);
          if (out_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    // base ops
    add(32'h7FFF_FFFF, 32'h1,         3'd0, 1'b0, 1'b0, 32'h8000_0000, 1);
    add(32'h0,         32'h1,         3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1);
    add(32'h8000_0000, 32'd31,        3'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, 1);
    add(32'h8000_0000, 32'd4,         3'd5, 1'b0, 1'b0, 32'h0800_0000, 1);
    add(32'h1,         32'hFFFF_FFFF, 3'd3, 1'b0, 1'b0, 32'h1,         1);
    add(32'h1,         32'hFFFF_FFFF, 3'd2, 1'b0, 1'b0, 32'h0,         1);
    add(32'h1,         32'd35,        3'd1, 1'b0, 1'b0, 32'h8,         1);
    add(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 1'b0, 1'b0, 32'h0FF0_0FF0, 1);
    add(32'hF0F0_F0F0, 32'h0F0F_0000, 3'd6, 1'b0, 1'b0, 32'hFFFF_F0F0, 1);
    add(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 1'b0, 1'b0, 32'hF000_F000, 1);
    // multiply
    add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFE, 33);
    add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1, 32'h0000_0001, 33);
    add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0, 1'b1, 32'h0,         33);
    add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 33);
    add(32'h8000_0000, 32'h2,         3'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 33);
    // divide
    add(32'hFFFF_FFF9, 32'h2,         3'd4, 1'b0, 1'b1, 32'hFFFF_FFFD, 33);
    add(32'hFFFF_FFF9, 32'h2,         3'd6, 1'b0, 1'b1, 32'hFFFF_FFFF, 33);
    add(32'd7,         32'hFFFF_FFFE, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFFD, 33);
    add(32'd7,         32'hFFFF_FFFE, 3'd6, 1'b0, 1'b1, 32'h1,         33);
    add(32'd100,       32'd7,         3'd5, 1'b0, 1'b1, 32'd14,        33);
    add(32'd100,       32'd7,         3'd7, 1'b0, 1'b1, 32'd2,         33);
    add(32'h8000_0000, 32'hFFFF_FFFF, 3'd5, 1'b0, 1'b1, 32'h0,         33);
    add(32'h8000_0000, 32'hFFFF_FFFF, 3'd7, 1'b0, 1'b1, 32'h8000_0000, 33);
    // divide special cases
    add(32'd5,         32'd0,         3'd4, 1'b0, 1'b1, 32'hFFFF_FFFF, 1);
    add(32'd5,         32'd0,         3'd6, 1'b0, 1'b1, 32'd5,         1);
    add(32'd5,         32'd0,         3'd5, 1'b0, 1'b1, 32'hFFFF_FFFF, 1);
    add(32'd5,         32'd0,         3'd7, 1'b0, 1'b1, 32'd5,         1);
    add(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 1);
    add(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 32'h0,         1);

    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], 0, 1'b0);

    // backpressure after a MUL: result held, in_ready low
    v = vecs[0];
    v.op1 = 32'h1234_5678; v.op2 = 32'h10; v.f3 = 3'd0; v.sub = 1'b0; v.md = 1'b1;
    v.res = 32'h2345_6780; v.lat = 33;
    run_vec(v, 10, 1'b0);

    // input activity during MULHU ignored
    v.op1 = 32'h8000_0000; v.op2 = 32'h4; v.f3 = 3'd3; v.res = 32'h2; v.lat = 33;
    run_vec(v, 0, 1'b1);

    // model-only operand sweep
    for (int i = 0; i < 16; i++) begin
      v.op1 = $urandom;
      v.op2 = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
      v.f3 = 3'($urandom); v.sub = 1'($urandom); v.md = 1'($urandom);
      v.pinned = 1'b0;
      v.res = model(v);
      v.lat = mlat(v);
      run_vec(v, 0, 1'b0);
    end

    // MUL_STEP=4 instance: 9-cycle multiply
    chk("step4_in_ready", 32'(in_ready4), 32'd1);
    op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; funct3 = 3'd3; is_muldiv = 1'b1;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (out_valid4 || n >= 100) break;
    end
    chk("step4_latency", 32'(n), 32'd9);
    chk("step4_result", result4, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    // asynchronous reset mid-DIV, then a clean ADD
    v.op1 = 32'd100; v.op2 = 32'd7; v.f3 = 3'd5; v.sub = 1'b0; v.md = 1'b1;
    v.res = 32'd14; v.lat = 33; v.pinned = 1'b1;
    launch(v);
    repeat (10) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    v.op1 = 32'd3; v.op2 = 32'd4; v.f3 = 3'd0; v.md = 1'b0; v.res = 32'd7; v.lat = 1;
    run_vec(v, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
